// File: rtl/module_countdown_8_bit_pkg.sv
// Shared definitions for the 8-bit loadable down-counter: data width and FSM state encoding.
`default_nettype none

package module_countdown_8_bit_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/module_countdown_8_bit_if.sv
// Control/status bundle of the down-counter; the counter is the slave, its driver the master.
`default_nettype none

interface module_countdown_8_bit_if;
  import module_countdown_8_bit_pkg::*;

  logic             en_in;
  logic             load_in;
  logic             start_in;
  logic             reload_in;
  logic [CNT_W-1:0] preset_in;
  logic [CNT_W-1:0] out;
  logic             borrow;
  logic             busy;
  logic             done;

  modport master (
    output en_in, load_in, start_in, reload_in, preset_in,
    input  out, borrow, busy, done
  );

  modport slave (
    input  en_in, load_in, start_in, reload_in, preset_in,
    output out, borrow, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/module_countdown_8_bit.sv
// 8-bit loadable down-counter with IDLE/RUN/DONE control, sticky done flag and optional auto-reload.
`default_nettype none

module module_countdown_8_bit
  import module_countdown_8_bit_pkg::*;
#(
  parameter bit AUTO_START = 1'b0
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  module_countdown_8_bit_if.slave   bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic             borrow_q, borrow_d;
  logic             done_q, done_d;

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    reload_d = reload_q;
    borrow_d = 1'b0;
    done_d   = done_q;

    if (bus.load_in) begin
      // A load overrides everything else, including an expiry in flight.
      out_d    = bus.preset_in;
      reload_d = bus.preset_in;
      done_d   = 1'b0;
      state_d  = (AUTO_START && (bus.preset_in != '0)) ? ST_RUN : ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start_in && (out_q != '0)) begin
            state_d = ST_RUN;
            done_d  = 1'b0;
          end
        end
        ST_RUN: begin
          if (bus.en_in) begin
            // Treat out<=1 as the final tick so the count can never wrap.
            if (out_q <= CNT_W'(1)) begin
              out_d    = '0;
              borrow_d = 1'b1;
              done_d   = 1'b1;
              state_d  = ST_DONE;
            end else begin
              out_d = out_q - CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (bus.reload_in && (reload_q != '0)) begin
            out_d   = reload_q;
            state_d = ST_RUN;
          end else begin
            out_d   = '0;
            state_d = ST_IDLE;
          end
        end
        default: begin
          out_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= ST_IDLE;
      out_q    <= '0;
      reload_q <= '0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      reload_q <= reload_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
    end
  end

  assign bus.out    = out_q;
  assign bus.borrow = borrow_q;
  assign bus.busy   = (state_q == ST_RUN);
  assign bus.done   = done_q;

endmodule

`default_nettype wire

// File: doc/module_countdown_8_bit.md
MODULE_COUNTDOWN_8_BIT -- requirements
Module: module_countdown_8_bit

Interface
REQ-001 Parameter AUTO_START, default 0: when 1, an accepted load also starts a run in the same edge.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk_in  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n_in  input  1  asynchronous active-low reset.
REQ-005 en_in  input  1  count tick, e.g. the carry of an up-counter; decrement only when high.
REQ-006 load_in  input  1  load preset_in into the counter and the reload register.
REQ-007 start_in  input  1  begin counting down from the current value.
REQ-008 reload_in  input  1  auto-reload select, sampled in DONE.
REQ-009 preset_in  input  8  start value, unsigned.
REQ-010 out  output  8  current count, registered.
REQ-011 borrow  output  1  registered one-cycle pulse when the count reaches 0.
REQ-012 busy  output  1  high while in RUN.
REQ-013 done  output  1  sticky expiry flag.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 In any state, load_in=1 SHALL set out and the reload register to preset_in, clear done and go to IDLE; with AUTO_START=1 and preset_in!=0 it SHALL go to RUN instead.
REQ-016 load_in SHALL take priority over start_in, en_in and reload_in in the same cycle; a load during RUN aborts the run without a borrow pulse.
REQ-017 In IDLE, start_in=1 with out!=0 SHALL go to RUN and clear done; start_in with out==0 SHALL be ignored.
REQ-018 In RUN, start_in SHALL be ignored.
REQ-019 In RUN with en_in=0, out SHALL hold.
REQ-020 In RUN with en_in=1 and out>1, out SHALL decrement by 1 per edge.
REQ-021 In RUN with en_in=1 and out==1, the edge SHALL make out=0, borrow=1, done=1 and go to DONE.
REQ-022 Latency: borrow SHALL be high exactly in the cycle following the final decrementing edge.
REQ-023 There SHALL be no wrap from 0 to 255 under any input.
REQ-024 DONE SHALL last exactly one cycle; borrow SHALL be high only in DONE.
REQ-025 Leaving DONE with reload_in=1 SHALL set out to the reload register and go to RUN.
REQ-026 Leaving DONE with reload_in=0 SHALL go to IDLE with out=0.
REQ-027 done SHALL stay high until the next accepted load or start.
REQ-028 busy SHALL be high exactly when the state is RUN.
REQ-029 en_in SHALL be ignored outside RUN.
REQ-030 preset_in SHALL be treated as unsigned 8-bit; preset 255 SHALL take 255 enabled ticks to expire.

Reset
REQ-031 While rst_n_in=0, the block SHALL immediately force state=IDLE, out=0, reload register=0, borrow=0, done=0 and busy=0, independent of clk_in.
REQ-032 Assertion of rst_n_in mid-run SHALL abort the run with no borrow pulse.
REQ-033 After reset release, the block SHALL act on load_in and start_in from the first rising edge.

Structure
REQ-034 A shared package SHALL hold the state encoding (IDLE=0, RUN=1, DONE=2, 2-bit) and the width constant 8.
REQ-035 The block SHALL be one module with no sub-module; the FSM and datapath SHALL share a single sequential process.

Verification
REQ-036 Load 5, start, en_in held high -> out 4,3,2,1,0 on consecutive edges; borrow one cycle with out=0; done sticky; busy low afterwards.
REQ-037 Load 3, start, en_in toggling 1,0,1,0,1 -> out 2,2,1,1,0; borrow in the cycle after the fifth edge.
REQ-038 Load 2, start, reload_in=1 at DONE -> out 2,1,0,2,1,0, ...; borrow every 3rd cycle; busy low only in the DONE cycles.
REQ-039 Load 0, then start -> state stays IDLE, out=0, no borrow; start and load 7 in the same cycle -> out=7, IDLE.
REQ-040 Load 9, start, run to out=4, assert rst_n_in between edges -> out=0 and borrow/done/busy=0 immediately, before the next clock edge.
REQ-041 AUTO_START=1, load 1, en_in=1 -> RUN on the load edge, borrow the next cycle; load 200 during RUN -> out=200 and run restarts without borrow.
